// File: rtl/restoring_divider.sv
// ============================================================================
// Module   : restoring_divider
// Brief    : Sequential unsigned restoring divider, one trial subtraction per
//            clock, start/busy/done handshake, divide-by-zero flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module restoring_divider #(
  parameter int WIDTH = 4
) (
  input  logic             DV_CLK,
  input  logic             DV_RST,
  input  logic             DV_START,
  input  logic [WIDTH-1:0] DV_DIVIDEND,
  input  logic [WIDTH-1:0] DV_DIVISOR,
  output logic             DV_BUSY,
  output logic             DV_DONE,
  output logic [WIDTH-1:0] DV_Q,
  output logic [WIDTH-1:0] DV_R,
  output logic             DV_DZ
);

  localparam int                 c_CW   = $clog2(WIDTH);
  localparam logic [c_CW-1:0]    c_LAST = c_CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_sreg;
  logic [WIDTH-1:0] r_dvsr;
  logic [c_CW-1:0]  r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic             r_dz;

  logic [WIDTH:0]   w_shift_rem;
  logic [WIDTH:0]   w_trial;
  logic             w_borrow;
  logic [WIDTH-1:0] w_new_rem;
  logic [WIDTH-1:0] w_new_sreg;

  // r_sreg shifts dividend bits out of the top while quotient bits enter at the bottom
  assign w_shift_rem = {r_rem, r_sreg[WIDTH-1]};
  assign w_trial     = w_shift_rem - {1'b0, r_dvsr};
  assign w_borrow    = w_trial[WIDTH];
  assign w_new_rem   = w_borrow ? w_shift_rem[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign w_new_sreg  = {r_sreg[WIDTH-2:0], ~w_borrow};

  always_ff @(posedge DV_CLK) begin
    if (DV_RST) begin
      r_state <= S_IDLE;
      r_rem   <= '0;
      r_sreg  <= '0;
      r_dvsr  <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_q     <= '0;
      r_r     <= '0;
      r_dz    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_CALC: begin
          r_rem  <= w_new_rem;
          r_sreg <= w_new_sreg;
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == c_LAST) begin
            r_state <= S_FIN;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_q     <= w_new_sreg;
            r_r     <= w_new_rem;
            r_dz    <= 1'b0;
          end
        end
        default: begin
          // IDLE and FIN both accept a new request
          r_state <= S_IDLE;
          if (DV_START) begin
            r_dvsr <= DV_DIVISOR;
            r_cnt  <= '0;
            r_rem  <= '0;
            r_sreg <= DV_DIVIDEND;
            if (DV_DIVISOR == '0) begin
              r_state <= S_FIN;
              r_done  <= 1'b1;
              r_q     <= '1;
              r_r     <= DV_DIVIDEND;
              r_dz    <= 1'b1;
            end else begin
              r_state <= S_CALC;
              r_busy  <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign DV_BUSY = r_busy;
  assign DV_DONE = r_done;
  assign DV_Q    = r_q;
  assign DV_R    = r_r;
  assign DV_DZ   = r_dz;

endmodule

`default_nettype wire
